dff_delay_line: RTL
===================

Name: dff_delay_line

Overview:
Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit registered delay line.
- Has clock-enable stall, per-stage valid tracking, synchronous flush, a selectable tap output and an occupancy count.
- Sits between the tile's dedicated inputs and outputs as a configurable sampling/retiming pipeline.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of stages (>=1)
- RESET_VAL, 0, value loaded into every stage's data on rst or flush (WIDTH bits)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  advance: when high, every stage shifts one position toward the output
- flush  input  1  synchronous clear of all stages
- din  input  WIDTH  data into stage 0
- din_valid  input  1  valid flag captured with din
- tap_sel  input  max(1,$clog2(DEPTH))  selects stage shown on tap_out
- dout  output  WIDTH  data of stage DEPTH-1
- dout_valid  output  1  valid of stage DEPTH-1
- tap_out  output  WIDTH  data of stage tap_sel
- tap_valid  output  1  valid of stage tap_sel
- occupancy  output  $clog2(DEPTH+1)  count of valid stages
- rise  output  WIDTH  per-bit rising edge, stage1 vs stage0 (optional feature)
- fall  output  WIDTH  per-bit falling edge (optional feature)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. No asynchronous paths.
- Priority per edge: rst > flush > en > hold.
- rst or flush: all stage data = RESET_VAL; all valid = 0. Outputs after the edge:
  - dout = RESET_VAL, dout_valid = 0
  - tap_out = RESET_VAL, tap_valid = 0
  - occupancy = 0, rise = fall = 0
- en=1: stage0 <= {din, din_valid}; stage[i] <= stage[i-1] for i = 1..DEPTH-1. Data leaving stage DEPTH-1 is discarded.
- en=0: all stages hold. din and din_valid are ignored.
- Latency: a sample captured at enabled edge N appears on dout after DEPTH enabled edges. Disabled cycles add delay but never drop or duplicate data.
- A stage's data shifts regardless of its valid bit; a bubble (din_valid=0) propagates as valid=0.
- DEPTH=1: stage 0 is also the output stage. tap_sel is 1 bit, and only value 0 is in range.
- Outputs dout, dout_valid, tap_out, tap_valid are combinational reads of stage registers; no extra output register.
- tap_sel >= DEPTH: tap_out = 0, tap_valid = 0 (not RESET_VAL).
- occupancy:
  - Registered counter, updated on the same edge as the stages; must always equal the popcount of the valid bits.
  - On en: next = occupancy + din_valid − valid[DEPTH-1].
  - Saturates at DEPTH by construction. Never wraps.
- flush and en both high: flush wins; din is not captured.
- rst mid-stream: all in-flight data is lost. The first enabled edge after rst deasserts captures din normally.

Optional Feature:
Macro DFF_DELAY_EDGE_EN.
- Defined:
  - rise = stage0 & ~stage1 and fall = ~stage0 & stage1, per bit, gated by valid0 & valid1; combinational.
  - Requires DEPTH>=2. With DEPTH=1, rise = fall = 0.
- Not defined: rise and fall ports still exist (stable port list) and are tied to 0. No edge logic is synthesised.

Decomposition:
- Package dff_delay_pkg:
  - default WIDTH/DEPTH constants
  - a clog2-with-minimum-1 function for the tap_sel and occupancy widths
  - stage record typedef {valid, data}
- Sub-module dff_stage: one WIDTH-bit enabled register plus valid bit, with synchronous rst/flush to RESET_VAL/0. Instantiated DEPTH times in a generate loop.
- Top level holds the tap mux, occupancy counter and optional edge logic.

Test Plan:
1. WIDTH=8, DEPTH=4; rst high 2 cycles → dout=0x00, dout_valid=0, occupancy=0. Then en=1 with din=0x11,0x22,0x33,0x44, all valid → dout=0x11, dout_valid=1 on the 4th edge; occupancy=4.
2. Stall: same stream, but en=0 for 3 cycles after the second sample → dout=0x11 appears after 7 edges. Order is 0x11,0x22,0x33,0x44 with no duplicates.
3. Bubbles: din_valid pattern 1,0,1,0 with en=1 → occupancy sequence 1,1,2,2. dout_valid toggles 1,0,1,0 starting at edge 4.
4. Flush and en both high with the pipe full → next cycle occupancy=0, all valid=0, dout=RESET_VAL, and din was not captured.
5. Tap: pipe holds 0x44,0x33,0x22,0x11 (stage0..3) → tap_sel=2 gives 0x22, tap_valid=1. With DEPTH=3 and tap_sel=3 → tap_out=0, tap_valid=0.
6. With DFF_DELAY_EDGE_EN defined: stage1=0x0F, stage0=0x3C, both valid → rise=0x30, fall=0x03. Without the macro → rise=fall=0x00.

Source files
------------

// File: rtl/dff_delay_pkg.sv
// Shared constants, width helper and stage record for the dff_delay_line block.
package dff_delay_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Select and count widths never collapse to zero bits, even for DEPTH=1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One pipeline stage as seen from outside: valid flag plus data word.
  typedef struct packed {
    logic                     valid;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/dff_stage.sv
// One stage of the delay line: WIDTH-bit data register plus valid bit.
// rst (synchronous, highest priority) and flush load RESET_VAL / invalid;
// en captures the upstream stage; otherwise the stage holds.
module dff_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d_data,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // Next-state: flush beats en, en beats hold.
  always_comb begin
    // NOTE: hold values are assigned first so every path drives both signals and no latch is inferred.
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = d_data;
      valid_d = d_valid;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments let every stage sample its neighbour's pre-edge value.
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q_data  = data_q;
  assign q_valid = valid_q;

endmodule

// File: rtl/dff_delay_line.sv
// DEPTH-stage, WIDTH-bit registered delay line with clock-enable stall,
// per-stage valid, synchronous flush, tap output and occupancy count.
// Optional edge detector between stage 0 and stage 1 is built only when the
// macro DFF_DELAY_EDGE_EN is defined; otherwise rise/fall are tied to 0.
module dff_delay_line
  import dff_delay_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            flush,
  input  logic [WIDTH-1:0]                din,
  input  logic                            din_valid,
  input  logic [clog2_min1(DEPTH)-1:0]    tap_sel,
  output logic [WIDTH-1:0]                dout,
  output logic                            dout_valid,
  output logic [WIDTH-1:0]                tap_out,
  output logic                            tap_valid,
  output logic [clog2_min1(DEPTH+1)-1:0]  occupancy,
  output logic [WIDTH-1:0]                rise,
  output logic [WIDTH-1:0]                fall
);

  localparam int OCC_W = clog2_min1(DEPTH + 1);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] stage_valid;

  // Stage chain: stage 0 takes din, stage i takes stage i-1.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_valid;

    if (i == 0) begin : g_head
      assign in_data  = din;
      assign in_valid = din_valid;
    end else begin : g_link
      assign in_data  = stage_data[i-1];
      assign in_valid = stage_valid[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .en      (en),
      .d_data  (in_data),
      .d_valid (in_valid),
      .q_data  (stage_data[i]),
      .q_valid (stage_valid[i])
    );
  end

  assign dout       = stage_data[DEPTH-1];
  assign dout_valid = stage_valid[DEPTH-1];

  // Tap mux: out-of-range selects read as zero, not RESET_VAL.
  always_comb begin
    tap_out   = '0;
    tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(tap_sel) == i) begin
        tap_out   = stage_data[i];
        tap_valid = stage_valid[i];
      end
    end
  end

  logic [OCC_W-1:0] occ_d, occ_q;

  // Occupancy tracks the popcount of valid bits: one in at stage 0, one out at the last stage.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OCC_W'(din_valid) - OCC_W'(stage_valid[DEPTH-1]);
    end
  end

  // Occupancy register, cleared by reset alongside the stages.
  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

`ifdef DFF_DELAY_EDGE_EN
  // Per-bit edge detect between the two youngest stages, only when both hold valid data.
  if (DEPTH >= 2) begin : g_edge
    logic both_valid;
    assign both_valid = stage_valid[0] & stage_valid[1];
    assign rise = stage_data[0] & ~stage_data[1] & {WIDTH{both_valid}};
    assign fall = ~stage_data[0] & stage_data[1] & {WIDTH{both_valid}};
  end else begin : g_no_edge
    assign rise = '0;
    assign fall = '0;
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
